// File: rtl/digit_entry_ctrl.sv
// Four-digit code entry sequencer: button edge detection, digit/cursor registers,
// check/unlock/lockout FSM and anode scan. Optional auto-repeat: DIGIT_ENTRY_AUTO_REPEAT_EN.
module digit_entry_ctrl #(
  parameter int          MAX_VAL        = 9,
  parameter logic [15:0] PASSCODE       = 16'h1234,
  parameter int          MAX_TRIES      = 3,
  parameter int          LOCKOUT_CYCLES = 100_000_000,
  parameter int          SCAN_DIV       = 100_000
`ifdef DIGIT_ENTRY_AUTO_REPEAT_EN
  , parameter int        REPEAT_DELAY   = 50_000_000
  , parameter int        REPEAT_PERIOD  = 10_000_000
`endif
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_center,
  output logic [15:0] digits,
  output logic [1:0]  cursor,
  output logic [1:0]  state,
  output logic        unlocked,
  output logic        fail_pulse,
  output logic [3:0]  an,
  output logic [3:0]  scan_val
);

  typedef enum logic [1:0] {
    EDIT    = 2'b00,
    CHECK   = 2'b01,
    OPEN    = 2'b10,
    LOCKOUT = 2'b11
  } state_t;

  localparam logic [3:0] MAX_D = 4'(MAX_VAL);
  localparam int FW = (MAX_TRIES > 0) ? $clog2(MAX_TRIES + 1) : 1;
  localparam int TW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  state_t        state_q, state_d;
  logic [3:0]    dig_q [4];
  logic [3:0]    dig_d [4];
  logic [1:0]    cur_q, cur_d;
  logic [FW-1:0] fail_q, fail_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [4:0]    prev_q;
  logic [SW-1:0] scan_cnt_q;
  logic [1:0]    scan_idx_q;

  logic rise_up, rise_dn, rise_l, rise_r, rise_c;
  logic rep_up, rep_dn;
  logic [3:0] sel;

  // Button order in prev_q: {center, right, left, down, up}
  assign rise_up = btn_up     & ~prev_q[0];
  assign rise_dn = btn_down   & ~prev_q[1];
  assign rise_l  = btn_left   & ~prev_q[2];
  assign rise_r  = btn_right  & ~prev_q[3];
  assign rise_c  = btn_center & ~prev_q[4];
  assign sel     = dig_q[cur_q];

`ifdef DIGIT_ENTRY_AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          rep_armed_q, rep_armed_d;
  logic          rep_step;

  // Wait REPEAT_DELAY while held (armed phase), then step every REPEAT_PERIOD.
  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_armed_d = rep_armed_q;
    rep_step    = 1'b0;
    if (state_q != EDIT || !(btn_up || btn_down) || rise_c || rise_up || rise_dn) begin
      rep_cnt_d   = '0;
      rep_armed_d = 1'b0;
    end else if (!rep_armed_q) begin
      if (rep_cnt_q == RW'(REPEAT_DELAY - 1)) begin
        rep_armed_d = 1'b1;
        rep_cnt_d   = '0;
      end else begin
        rep_cnt_d = rep_cnt_q + 1'b1;
      end
    end else if (rep_cnt_q == RW'(REPEAT_PERIOD - 1)) begin
      rep_step  = 1'b1;
      rep_cnt_d = '0;
    end else begin
      rep_cnt_d = rep_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      rep_cnt_q   <= '0;
      rep_armed_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_armed_q <= rep_armed_d;
    end
  end

  assign rep_up = rep_step & btn_up;
  assign rep_dn = rep_step & ~btn_up & btn_down;
`else
  assign rep_up = 1'b0;
  assign rep_dn = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    dig_d      = dig_q;
    cur_d      = cur_q;
    fail_d     = fail_q;
    tmr_d      = tmr_q;
    fail_pulse = 1'b0;
    case (state_q)
      EDIT: begin
        if (rise_c) begin
          state_d = CHECK;
        end else if (rise_up || rep_up) begin
          dig_d[cur_q] = (sel == MAX_D) ? 4'd0 : sel + 4'd1;
        end else if (rise_dn || rep_dn) begin
          dig_d[cur_q] = (sel == 4'd0) ? MAX_D : sel - 4'd1;
        end else if (rise_l) begin
          cur_d = cur_q + 2'd1;
        end else if (rise_r) begin
          cur_d = cur_q - 2'd1;
        end
      end
      CHECK: begin
        if (digits == PASSCODE) begin
          state_d = OPEN;
          fail_d  = '0;
        end else begin
          fail_pulse = 1'b1;
          fail_d     = fail_q + 1'b1;
          dig_d      = '{default: 4'd0};
          cur_d      = 2'd0;
          if (fail_q + 1'b1 == FW'(MAX_TRIES)) begin
            state_d = LOCKOUT;
            tmr_d   = TW'(LOCKOUT_CYCLES - 1);
          end else begin
            state_d = EDIT;
          end
        end
      end
      OPEN: begin
        if (rise_c) begin
          state_d = EDIT;
          dig_d   = '{default: 4'd0};
          cur_d   = 2'd0;
        end
      end
      LOCKOUT: begin
        // Timer counts LOCKOUT_CYCLES-1 down to 0, so exactly LOCKOUT_CYCLES clocks here.
        if (tmr_q == '0) begin
          state_d = EDIT;
          fail_d  = '0;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: state_d = EDIT;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= EDIT;
      dig_q   <= '{default: 4'd0};
      cur_q   <= 2'd0;
      fail_q  <= '0;
      tmr_q   <= '0;
      prev_q  <= 5'd0;
    end else begin
      state_q <= state_d;
      dig_q   <= dig_d;
      cur_q   <= cur_d;
      fail_q  <= fail_d;
      tmr_q   <= tmr_d;
      prev_q  <= {btn_center, btn_right, btn_left, btn_down, btn_up};
    end
  end

  // Free-running scan, independent of FSM state.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      scan_cnt_q <= '0;
      scan_idx_q <= 2'd0;
    end else if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
      scan_cnt_q <= '0;
      scan_idx_q <= scan_idx_q + 2'd1;
    end else begin
      scan_cnt_q <= scan_cnt_q + 1'b1;
    end
  end

  assign digits   = {dig_q[3], dig_q[2], dig_q[1], dig_q[0]};
  assign cursor   = cur_q;
  assign state    = state_q;
  assign unlocked = (state_q == OPEN);
  assign an       = ~(4'b0001 << scan_idx_q);
  assign scan_val = (state_q == LOCKOUT) ? 4'hF : dig_q[scan_idx_q];

endmodule
